// File: rtl/pattern_sequence_generator_pkg.sv
// Shared definitions for the serial pattern generator and the sequence-detector benches.
package pattern_sequence_generator_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] SEND = 2'b01;
  localparam logic [1:0] GAP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_SEND = SEND,
    ST_GAP  = GAP
  } state_t;

  localparam logic [2:0] PAT_101 = 3'b101;

endpackage

// File: rtl/pattern_sequence_generator_down_counter.sv
// Loadable down counter that saturates at zero; load takes priority over decrement.
module down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - ONE;
    end
  end

  assign is_zero = (count_reg == '0);

endmodule

// File: rtl/pattern_sequence_generator.sv
// Serial MSB-first pattern transmitter with repeat count and inter-repetition idle gaps.
module pattern_sequence_generator
  import pattern_sequence_generator_pkg::*;
#(
  parameter int PAT_W = 3,
  parameter int REP_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  state_t           state_reg;
  logic [PAT_W-1:0] pat_reg;
  logic [PAT_W-1:0] shift_reg;
  logic [GAP_W-1:0] gap_reg;
  logic             x_reg;
  logic             x_valid_reg;
  logic             busy_reg;
  logic             done_reg;

  logic bit_load, bit_dec, bit_zero;
  logic rep_load, rep_dec, rep_zero;
  logic gap_load, gap_dec, gap_zero;
  logic start_ok;

  assign start_ok = start && !abort && (reps != '0);

  // Bit index counts the bit currently on x; rep counter holds repetitions remaining after
  // the current one; gap counter is loaded with gap-1 so zero marks the last idle cycle.
  always_comb begin
    bit_load = 1'b0;
    bit_dec  = 1'b0;
    rep_load = 1'b0;
    rep_dec  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_ok) begin
          bit_load = 1'b1;
          rep_load = 1'b1;
        end
      end
      ST_SEND: begin
        if (!abort) begin
          if (!bit_zero) begin
            bit_dec = 1'b1;
          end else if (!rep_zero) begin
            rep_dec = 1'b1;
            if (gap_reg == '0) bit_load = 1'b1;
            else               gap_load = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (!abort) begin
          if (gap_zero) bit_load = 1'b1;
          else          gap_dec  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  down_counter #(.W(BIT_W)) u_bit_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (bit_load),
    .load_val (BIT_LAST),
    .dec      (bit_dec),
    .is_zero  (bit_zero)
  );

  down_counter #(.W(REP_W)) u_rep_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (rep_load),
    .load_val (reps - REP_ONE),
    .dec      (rep_dec),
    .is_zero  (rep_zero)
  );

  down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (gap_load),
    .load_val (gap_reg - GAP_ONE),
    .dec      (gap_dec),
    .is_zero  (gap_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      pat_reg     <= '0;
      shift_reg   <= '0;
      gap_reg     <= '0;
      x_reg       <= 1'b0;
      x_valid_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          x_reg       <= 1'b0;
          x_valid_reg <= 1'b0;
          busy_reg    <= 1'b0;
          if (start_ok) begin
            pat_reg     <= pattern;
            gap_reg     <= gap;
            x_reg       <= pattern[PAT_W-1];
            shift_reg   <= pattern << 1;
            x_valid_reg <= 1'b1;
            busy_reg    <= 1'b1;
            state_reg   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (abort) begin
            state_reg   <= ST_IDLE;
            x_reg       <= 1'b0;
            x_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
          end else if (!bit_zero) begin
            x_reg     <= shift_reg[PAT_W-1];
            shift_reg <= shift_reg << 1;
          end else if (!rep_zero) begin
            if (gap_reg == '0) begin
              x_reg     <= pat_reg[PAT_W-1];
              shift_reg <= pat_reg << 1;
            end else begin
              state_reg   <= ST_GAP;
              x_reg       <= 1'b0;
              x_valid_reg <= 1'b0;
            end
          end else begin
            state_reg   <= ST_IDLE;
            x_reg       <= 1'b0;
            x_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
          end
        end
        ST_GAP: begin
          if (abort) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else if (gap_zero) begin
            state_reg   <= ST_SEND;
            x_reg       <= pat_reg[PAT_W-1];
            shift_reg   <= pat_reg << 1;
            x_valid_reg <= 1'b1;
          end
          x_valid_reg <= !abort && gap_zero;
          x_reg       <= !abort && gap_zero && pat_reg[PAT_W-1];
        end
        default: begin
          state_reg   <= ST_IDLE;
          x_reg       <= 1'b0;
          x_valid_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign x       = x_reg;
  assign x_valid = x_valid_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_pattern_sequence_generator.sv
// Directed bench for pattern_sequence_generator; outputs checked as {x, x_valid, busy, done}.
module tb_pattern_sequence_generator;
  import pattern_sequence_generator_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] pattern = '0;
  logic [3:0] reps = '0;
  logic [2:0] gap = '0;
  logic       x, x_valid, busy, done;

  int total = 0;
  int bad   = 0;

  pattern_sequence_generator #(.PAT_W(3), .REP_W(4), .GAP_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .reps    (reps),
    .gap     (gap),
    .x       (x),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {x, x_valid, busy, done};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %s obs=%b exp=%b", tag, obs, exp);
  endtask

  task automatic chk_tick(input string tag, input logic [3:0] exp);
    chk(tag, exp);
    tick();
  endtask

  task automatic go(input logic [2:0] p, input logic [3:0] r, input logic [2:0] g);
    pattern = p;
    reps    = r;
    gap     = g;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    #2;
    chk("reset_async", 4'b0000);
    tick();
    chk("reset_held", 4'b0000);
    reset_n = 1'b1;
    tick();
    chk("idle_after_reset", 4'b0000);

    // single 101, done in cycle 4
    go(PAT_101, 4'd1, 3'd0);
    chk_tick("t1_c1", 4'b1110);
    chk_tick("t1_c2", 4'b0110);
    chk_tick("t1_c3", 4'b1110);
    chk_tick("t1_done", 4'b0001);
    chk_tick("t1_idle", 4'b0000);

    // two back-to-back repetitions
    go(PAT_101, 4'd2, 3'd0);
    chk_tick("t2_c1", 4'b1110);
    chk_tick("t2_c2", 4'b0110);
    chk_tick("t2_c3", 4'b1110);
    chk_tick("t2_c4", 4'b1110);
    chk_tick("t2_c5", 4'b0110);
    chk_tick("t2_c6", 4'b1110);
    chk_tick("t2_done", 4'b0001);
    chk_tick("t2_idle", 4'b0000);

    // two repetitions with a two-cycle gap
    go(PAT_101, 4'd2, 3'd2);
    chk_tick("t3_c1", 4'b1110);
    chk_tick("t3_c2", 4'b0110);
    chk_tick("t3_c3", 4'b1110);
    chk_tick("t3_gap1", 4'b0010);
    chk_tick("t3_gap2", 4'b0010);
    chk_tick("t3_c6", 4'b1110);
    chk_tick("t3_c7", 4'b0110);
    chk_tick("t3_c8", 4'b1110);
    chk_tick("t3_done", 4'b0001);
    chk_tick("t3_idle", 4'b0000);

    // pattern 110, two reps, one-cycle gap
    go(3'b110, 4'd2, 3'd1);
    chk_tick("t4_c1", 4'b1110);
    chk_tick("t4_c2", 4'b1110);
    chk_tick("t4_c3", 4'b0110);
    chk_tick("t4_gap", 4'b0010);
    chk_tick("t4_c5", 4'b1110);
    chk_tick("t4_c6", 4'b1110);
    chk_tick("t4_c7", 4'b0110);
    chk_tick("t4_done", 4'b0001);

    // abort in cycle 2 of a three-rep burst, then restart in cycle 5
    go(PAT_101, 4'd3, 3'd0);
    chk_tick("t5_c1", 4'b1110);
    chk("t5_c2", 4'b0110);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_tick("t5_abort_c3", 4'b0000);
    chk("t5_abort_c4", 4'b0000);
    tick();
    go(PAT_101, 4'd1, 3'd0);
    chk_tick("t5_restart_c6", 4'b1110);
    chk_tick("t5_restart_c7", 4'b0110);
    chk_tick("t5_restart_c8", 4'b1110);
    chk_tick("t5_restart_done", 4'b0001);

    // abort inside a gap
    go(PAT_101, 4'd2, 3'd3);
    chk_tick("t6_c1", 4'b1110);
    chk_tick("t6_c2", 4'b0110);
    chk_tick("t6_c3", 4'b1110);
    chk("t6_gap", 4'b0010);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_tick("t6_abort", 4'b0000);
    chk_tick("t6_after", 4'b0000);

    // start while busy ignored
    go(PAT_101, 4'd1, 3'd0);
    chk("t7_c1", 4'b1110);
    tick();
    pattern = 3'b010;
    reps    = 4'd3;
    start   = 1'b1;
    chk_tick("t7_c2", 4'b0110);
    start   = 1'b0;
    chk_tick("t7_c3", 4'b1110);
    chk_tick("t7_done", 4'b0001);
    chk_tick("t7_idle", 4'b0000);

    // reps==0 ignored
    go(PAT_101, 4'd0, 3'd0);
    chk_tick("t8_c1", 4'b0000);
    chk_tick("t8_c2", 4'b0000);

    // abort beats start in IDLE
    abort = 1'b1;
    go(PAT_101, 4'd1, 3'd0);
    abort = 1'b0;
    chk_tick("t9_c1", 4'b0000);
    chk_tick("t9_c2", 4'b0000);

    // async reset mid-SEND
    go(PAT_101, 4'd3, 3'd0);
    chk("t10_c1", 4'b1110);
    #2 reset_n = 1'b0;
    #1 chk("t10_rst_async", 4'b0000);
    tick();
    chk("t10_rst_held", 4'b0000);
    reset_n = 1'b1;
    tick();
    chk_tick("t10_idle1", 4'b0000);
    chk_tick("t10_idle2", 4'b0000);
    go(PAT_101, 4'd1, 3'd0);
    chk_tick("t10_restart", 4'b1110);
    tick();
    tick();
    chk_tick("t10_done", 4'b0001);

    // maximum burst: 15 back-to-back reps of 100
    go(3'b100, 4'd15, 3'd0);
    for (int i = 0; i < 45; i++) begin
      chk_tick($sformatf("t11_bit%0d", i), ((i % 3) == 0) ? 4'b1110 : 4'b0110);
    end
    chk_tick("t11_done", 4'b0001);
    chk_tick("t11_idle", 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
